// File: rtl/svm_pkg.sv
// svm_pkg
// Shared parameters and types for the stage-1 SVM classifier blocks
// (dot-product array, memory controller and decision function).
//   XLEN_PIXEL : base data width
//   NUM_OF_SV  : number of support vectors per decision
//   KW / CW    : kernel width and coefficient/bias width
//   ACC_W      : decision accumulator width
//   IDX_W      : width of the support-vector index counter
package svm_pkg;

  localparam int XLEN_PIXEL = 8;
  localparam int NUM_OF_SV  = 87;
  localparam int KW         = 5 * XLEN_PIXEL;
  localparam int CW         = 2 * XLEN_PIXEL;
  localparam int ACC_W      = 64;
  localparam int IDX_W      = $clog2(NUM_OF_SV + 1);

  // Smallest accumulator that holds NUM_OF_SV worst-case signed products
  localparam int ACC_MIN_W  = KW + 1 + CW + $clog2(NUM_OF_SV);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_SV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINAL,
    ST_DONE
  } svm_state_e;

endpackage

// File: rtl/svm_signed_mac.sv
// svm_signed_mac
// Combinational multiply-accumulate step of the decision function:
//   acc_out = acc_in + sext(coef) * zext(kernel)
// Ports:
//   acc_in  : current signed accumulator value
//   coef    : signed two's-complement coefficient (alpha*y)
//   kernel  : unsigned kernel (dot-product) value
//   acc_out : updated signed accumulator value
module svm_signed_mac
  import svm_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic        [CW-1:0]    coef,
  input  logic        [KW-1:0]    kernel,
  output logic signed [ACC_W-1:0] acc_out
);

  logic signed [KW:0]    kernel_s;
  logic signed [CW-1:0]  coef_s;
  logic signed [KW+CW:0] prod;

  // A zero MSB keeps the unsigned kernel positive inside the signed multiply
  assign kernel_s = {1'b0, kernel};
  assign coef_s   = coef;
  assign prod     = kernel_s * coef_s;

  assign acc_out  = acc_in + {{(ACC_W-KW-CW-1){prod[KW+CW]}}, prod};

endmodule

// File: rtl/svm_decision_function.sv
// svm_decision_function
// Final stage of the stage-1 SVM classifier. Accumulates
// sum(coef[i] * kernel[i]) + b over all support vectors and emits a
// 1-bit class decision together with a one-cycle done pulse.
// Ports:
//   clk               : clock, all state on rising edge
//   rst               : synchronous active-high reset
//   decision_funct_en : level enable, high for the whole decision
//   kernel_out        : flattened unsigned kernels, SV i at [i*KW +: KW]
//   product           : signed coefficient for the current SV index
//   product_valid     : product is valid this cycle
//   b                 : signed bias, sampled in FINAL
//   y_class           : 1 when decision >= 0, held until next decision
//   done              : one-cycle pulse when y_class updates
//   busy              : high while accumulating or finalising
module svm_decision_function
  import svm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     decision_funct_en,
  input  logic [KW*NUM_OF_SV-1:0]  kernel_out,
  input  logic [CW-1:0]            product,
  input  logic                     product_valid,
  input  logic [CW-1:0]            b,
  output logic                     y_class,
  output logic                     done,
  output logic                     busy
);

  svm_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] final_sum;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    y_class_q, y_class_d;
  logic                    done_q, done_d;
  logic [KW-1:0]           kernel_slice;

  assign kernel_slice = kernel_out[idx_q*KW +: KW];

  svm_signed_mac u_mac (
    .acc_in  (acc_q),
    .coef    (product),
    .kernel  (kernel_slice),
    .acc_out (mac_sum)
  );

  assign final_sum = acc_q + {{(ACC_W-CW){b[CW-1]}}, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      y_class_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      y_class_q <= y_class_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_class_d = y_class_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A product_valid on the entering edge is deliberately dropped
        if (decision_funct_en) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      ST_ACCUM: begin
        if (!decision_funct_en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          idx_d   = '0;
        end else if (product_valid) begin
          acc_d = mac_sum;
          // Index wraps to 0 on the last accept so the mux never selects past the last SV
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_FINAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_FINAL: begin
        if (!decision_funct_en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          idx_d   = '0;
        end else begin
          // Sign bit clear means result >= 0, so an exact zero classifies as 1
          y_class_d = ~final_sum[ACC_W-1];
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!decision_funct_en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign y_class = y_class_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_ACCUM) || (state_q == ST_FINAL);

endmodule

// File: tb/tb_svm_decision_function.sv
// tb_svm_decision_function
// Self-checking bench for svm_decision_function. Expected class decisions
// come from a longint model of sum(coef*kernel)+b, are queued when a
// decision is launched and popped whenever the DUT pulses done.
module tb_svm_decision_function;
  import svm_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [KW*NUM_OF_SV-1:0] kernel_vec;
  logic [CW-1:0]           product;
  logic                    pv;
  logic [CW-1:0]           bias;
  logic                    y_class;
  logic                    done;
  logic                    busy;

  int     check_count = 0;
  int     fail_count  = 0;
  int     cycle_num   = 0;
  int     done_events = 0;
  int     last_done_cycle = 0;
  bit     exp_q[$];
  bit     exp_y = 1'b0;
  longint kern_val[NUM_OF_SV];
  int     coefs[NUM_OF_SV];

  always #5 clk = ~clk;

  svm_decision_function dut (
    .clk               (clk),
    .rst               (rst),
    .decision_funct_en (en),
    .kernel_out        (kernel_vec),
    .product           (product),
    .product_valid     (pv),
    .b                 (bias),
    .y_class           (y_class),
    .done              (done),
    .busy              (busy)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  always @(posedge clk) cycle_num <= cycle_num + 1;

  // Scoreboard consumer: every done pulse must match a queued decision
  always @(negedge clk) begin
    bit e;
    if (rst === 1'b0 && done === 1'b1) begin
      done_events++;
      last_done_cycle = cycle_num;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("y_class_on_done", {63'd0, y_class}, {63'd0, e});
      end
    end
  end

  task automatic setKernels(input longint v);
    for (int i = 0; i < NUM_OF_SV; i++) begin
      kern_val[i] = v;
      kernel_vec[i*KW +: KW] = v[KW-1:0];
    end
  endtask

  task automatic setCoefs(input int even_v, input int odd_v);
    for (int i = 0; i < NUM_OF_SV; i++)
      coefs[i] = (i % 2 == 0) ? even_v : odd_v;
  endtask

  // Runs one decision; abort_after > 0 drops enable after that many accepts
  task automatic applyStimulus(input string tag, input logic [CW-1:0] bias_val,
                               input bit gaps, input int abort_after);
    longint model;
    bit     expect_y;
    bit     phase;
    int     accepted;
    int     entry;
    int     start_events;
    int     waited;
    int     exp_lat;

    model = 0;
    for (int i = 0; i < NUM_OF_SV; i++)
      model += longint'(coefs[i]) * kern_val[i];
    model += longint'($signed(bias_val));
    expect_y = (model >= 0);
    if (abort_after == 0) exp_q.push_back(expect_y);

    bias = bias_val;
    start_events = done_events;
    // Junk valid on the entering edge must be ignored
    @(negedge clk);
    en = 1'b1; pv = 1'b1; product = 16'h7fff;
    @(negedge clk);
    entry = cycle_num;
    checkOutput({tag, "_busy_accum"}, {63'd0, busy}, 1);

    accepted = 0;
    phase = 1'b0;
    while (accepted < NUM_OF_SV && !(abort_after > 0 && accepted == abort_after)) begin
      if (gaps && phase) begin
        pv = 1'b0; product = 16'h7fff;
      end else begin
        pv = 1'b1; product = CW'(coefs[accepted]);
        accepted++;
      end
      phase = ~phase;
      @(negedge clk);
    end

    if (abort_after > 0) begin
      en = 1'b0; pv = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_busy_idle"}, {63'd0, busy}, 0);
      checkOutput({tag, "_y_unchanged"}, {63'd0, y_class}, {63'd0, exp_y});
      repeat (4) @(negedge clk);
      checkOutput({tag, "_no_done"}, done_events - start_events, 0);
      return;
    end

    // Keep valid high with junk data: FINAL and DONE must ignore it
    pv = 1'b1; product = 16'h7fff;
    exp_lat = (gaps ? 2*NUM_OF_SV - 1 : NUM_OF_SV) + 1;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (done_events == start_events && waited < 20);

    if (done_events == start_events) begin
      checkOutput({tag, "_done_timeout"}, 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      checkOutput({tag, "_latency"}, last_done_cycle - entry, exp_lat);
      exp_y = expect_y;
    end

    @(negedge clk);
    checkOutput({tag, "_done_pulse_low"}, {63'd0, done}, 0);
    checkOutput({tag, "_y_hold"}, {63'd0, y_class}, {63'd0, exp_y});
    checkOutput({tag, "_busy_done"}, {63'd0, busy}, 0);
    en = 1'b0; pv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pv = 1'b0; product = '0; bias = '0;
    setKernels(1);
    setCoefs(1, 1);
    repeat (2) @(negedge clk);
    checkOutput("reset_y_class", {63'd0, y_class}, 0);
    checkOutput("reset_done", {63'd0, done}, 0);
    checkOutput("reset_busy", {63'd0, busy}, 0);
    rst = 1'b0; en = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_busy", {63'd0, busy}, 0);
    checkOutput("idle_done_events", done_events, 0);

    $display("[TB] case: unit kernels, +1 coefs, b=0");
    applyStimulus("pos87", 16'h0000, 1'b0, 0);

    $display("[TB] case: large negative bias");
    applyStimulus("negbias", 16'h8001, 1'b0, 0);

    $display("[TB] case: gapped product_valid");
    applyStimulus("gaps", 16'h0000, 1'b1, 0);

    $display("[TB] case: max kernels, min coefs");
    setKernels(64'h0000_00ff_ffff_ffff);
    setCoefs(-32768, -32768);
    applyStimulus("overflow", 16'h0000, 1'b0, 0);

    $display("[TB] case: abort after 40 accepts");
    setKernels(1);
    setCoefs(-1000, -1000);
    applyStimulus("abort", 16'h0000, 1'b0, 40);

    $display("[TB] case: rerun after abort");
    setCoefs(1, 1);
    applyStimulus("rerun", 16'h0000, 1'b0, 0);

    applyStimulus("negbias2", 16'h8001, 1'b0, 0);

    $display("[TB] case: exact-zero tie");
    setKernels(10);
    setCoefs(100, -100);
    applyStimulus("tie", 16'hfc18, 1'b0, 0);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
